// File: rtl/toy_pack.sv
// Shared widths for the toy core pipeline.
package toy_pack;
  localparam int INST_WIDTH     = 32;
  localparam int INST_IDX_WIDTH = 6;
  localparam int ADDR_WIDTH     = 32;
  localparam int REG_WIDTH      = 32;
endpackage

// File: rtl/toy_mext.sv
// Iterative RV32M multiply/divide unit: one instruction in flight, one commit per instruction.
//
// state | meaning
// IDLE  | ready for a new instruction
// MUL   | registering the product
// DIV   | one restoring-divide quotient bit per cycle, cnt 31 down to 0
// DONE  | result held; writeback/commit registered on the following edge
module toy_mext
  import toy_pack::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mext_inst_vld,
  output logic                      mext_inst_rdy,
  input  logic [INST_WIDTH-1:0]     mext_inst_pld,
  input  logic [INST_IDX_WIDTH-1:0] mext_inst_idx,
  input  logic [4:0]                mext_inst_rd,
  input  logic                      mext_inst_rd_en,
  input  logic [ADDR_WIDTH-1:0]     mext_inst_pc,
  input  logic [REG_WIDTH-1:0]      mext_inst_rs1_val,
  input  logic [REG_WIDTH-1:0]      mext_inst_rs2_val,
  output logic                      mext_reg_wr_en,
  output logic [4:0]                mext_reg_wr_idx,
  output logic [REG_WIDTH-1:0]      mext_reg_wr_data,
  output logic                      mext_commit_vld,
  output logic [INST_IDX_WIDTH-1:0] mext_commit_idx
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t                      state, state_nxt;
  logic [2:0]                  f3;
  logic [INST_IDX_WIDTH-1:0]   idx_q;
  logic [4:0]                  rd_q;
  logic                        rd_en_q;
  logic [REG_WIDTH-1:0]        op_a, op_b, rem_q, result;
  logic [4:0]                  cnt;
  logic                        neg_q, neg_r;

  // pc and the non-funct3 payload bits travel with the instruction but feed nothing here
  logic unused_inputs;
  assign unused_inputs = ^{mext_inst_pc, mext_inst_pld[INST_WIDTH-1:15], mext_inst_pld[11:0]};

  logic                 accept, is_div_in, signed_in, sel_rem_in, div0_in, ovf_in, special_in;
  logic [REG_WIDTH-1:0] abs_a, abs_b, spec_res;

  assign mext_inst_rdy = (state == IDLE);
  assign accept        = mext_inst_rdy && mext_inst_vld;
  assign is_div_in     = mext_inst_pld[14];
  assign signed_in     = ~mext_inst_pld[12];
  assign sel_rem_in    = mext_inst_pld[13];
  assign div0_in       = (mext_inst_rs2_val == '0);
  assign ovf_in        = signed_in && (mext_inst_rs1_val == 32'h8000_0000) && (mext_inst_rs2_val == '1);
  assign special_in    = is_div_in && (div0_in || ovf_in);
  assign abs_a         = (signed_in && mext_inst_rs1_val[31]) ? -mext_inst_rs1_val : mext_inst_rs1_val;
  assign abs_b         = (signed_in && mext_inst_rs2_val[31]) ? -mext_inst_rs2_val : mext_inst_rs2_val;
  assign spec_res      = div0_in ? (sel_rem_in ? mext_inst_rs1_val : '1)
                                 : (sel_rem_in ? '0 : 32'h8000_0000);

  // Operands sign-extended to 64 bits; the low 64 bits of this product equal those of the 33x33 form.
  logic                 ext_a, ext_b;
  logic signed [63:0]   mul_a, mul_b, prod;
  logic [REG_WIDTH-1:0] mul_res;

  assign ext_a   = (f3 != 3'b011) && op_a[31];
  assign ext_b   = ~f3[1] && op_b[31];
  assign mul_a   = {{32{ext_a}}, op_a};
  assign mul_b   = {{32{ext_b}}, op_b};
  assign prod    = mul_a * mul_b;
  assign mul_res = (f3 == 3'b000) ? prod[31:0] : prod[63:32];

  // op_a doubles as the quotient shift register; op_b holds the divisor magnitude.
  logic [32:0]          diff;
  logic                 q_bit;
  logic [REG_WIDTH-1:0] rem_nxt, quo_nxt, q_fin, r_fin, div_res;

  assign diff    = {rem_q, op_a[31]} - {1'b0, op_b};
  assign q_bit   = ~diff[32];
  assign rem_nxt = q_bit ? diff[31:0] : {rem_q[30:0], op_a[31]};
  assign quo_nxt = {op_a[30:0], q_bit};
  assign q_fin   = neg_q ? -quo_nxt : quo_nxt;
  assign r_fin   = neg_r ? -rem_nxt : rem_nxt;
  assign div_res = f3[1] ? r_fin : q_fin;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) begin
              if (!is_div_in)      state_nxt = MUL;
              else if (special_in) state_nxt = DONE;
              else                 state_nxt = DIV;
            end
      MUL:  state_nxt = DONE;
      DIV:  if (cnt == 5'd0) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture, multiply and divide datapath; result is loaded on every entry into DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3 <= '0; idx_q <= '0; rd_q <= '0; rd_en_q <= 1'b0;
      op_a <= '0; op_b <= '0; rem_q <= '0; result <= '0;
      cnt <= '0; neg_q <= 1'b0; neg_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
                f3      <= mext_inst_pld[14:12];
                idx_q   <= mext_inst_idx;
                rd_q    <= mext_inst_rd;
                rd_en_q <= mext_inst_rd_en;
                neg_q   <= signed_in && (mext_inst_rs1_val[31] ^ mext_inst_rs2_val[31]);
                neg_r   <= signed_in && mext_inst_rs1_val[31];
                rem_q   <= '0;
                cnt     <= 5'd31;
                result  <= spec_res;
                op_a    <= is_div_in ? abs_a : mext_inst_rs1_val;
                op_b    <= is_div_in ? abs_b : mext_inst_rs2_val;
              end
        MUL:  result <= mul_res;
        DIV:  begin
                op_a  <= quo_nxt;
                rem_q <= rem_nxt;
                if (cnt == 5'd0) result <= div_res;
                else             cnt    <= cnt - 5'd1;
              end
        default: ;
      endcase
    end
  end

  // Writeback/commit registered from DONE so nothing reaches them combinationally from the issue port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mext_commit_vld  <= 1'b0;
      mext_commit_idx  <= '0;
      mext_reg_wr_en   <= 1'b0;
      mext_reg_wr_idx  <= '0;
      mext_reg_wr_data <= '0;
    end else if (state == DONE) begin
      mext_commit_vld  <= 1'b1;
      mext_commit_idx  <= idx_q;
      mext_reg_wr_en   <= rd_en_q && (rd_q != 5'd0);
      mext_reg_wr_idx  <= rd_q;
      mext_reg_wr_data <= result;
    end else begin
      mext_commit_vld  <= 1'b0;
      mext_commit_idx  <= '0;
      mext_reg_wr_en   <= 1'b0;
      mext_reg_wr_idx  <= '0;
      mext_reg_wr_data <= '0;
    end
  end

endmodule

// File: tb/tb_toy_mext.sv
// Scoreboard bench for toy_mext: driver pushes expected commits, negedge monitor pops and compares.
module tb_toy_mext;
  import toy_pack::*;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      mext_inst_vld;
  logic                      mext_inst_rdy;
  logic [INST_WIDTH-1:0]     mext_inst_pld;
  logic [INST_IDX_WIDTH-1:0] mext_inst_idx;
  logic [4:0]                mext_inst_rd;
  logic                      mext_inst_rd_en;
  logic [ADDR_WIDTH-1:0]     mext_inst_pc;
  logic [REG_WIDTH-1:0]      mext_inst_rs1_val;
  logic [REG_WIDTH-1:0]      mext_inst_rs2_val;
  logic                      mext_reg_wr_en;
  logic [4:0]                mext_reg_wr_idx;
  logic [REG_WIDTH-1:0]      mext_reg_wr_data;
  logic                      mext_commit_vld;
  logic [INST_IDX_WIDTH-1:0] mext_commit_idx;

  toy_mext dut (
    .clk(clk), .rst_n(rst_n),
    .mext_inst_vld(mext_inst_vld), .mext_inst_rdy(mext_inst_rdy),
    .mext_inst_pld(mext_inst_pld), .mext_inst_idx(mext_inst_idx),
    .mext_inst_rd(mext_inst_rd), .mext_inst_rd_en(mext_inst_rd_en),
    .mext_inst_pc(mext_inst_pc),
    .mext_inst_rs1_val(mext_inst_rs1_val), .mext_inst_rs2_val(mext_inst_rs2_val),
    .mext_reg_wr_en(mext_reg_wr_en), .mext_reg_wr_idx(mext_reg_wr_idx),
    .mext_reg_wr_data(mext_reg_wr_data),
    .mext_commit_vld(mext_commit_vld), .mext_commit_idx(mext_commit_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [INST_IDX_WIDTH-1:0] idx;
    logic                      wr_en;
    logic [4:0]                rd;
    logic [31:0]               data;
    int                        acc;
    int                        lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [INST_IDX_WIDTH-1:0] tag = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic following the RV32M rules
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sa, sb_v;
    sa = a; sb_v = b;
    case (f3)
      3'd0: begin p = longint'(sa) * longint'(sb_v); return p[31:0]; end
      3'd1: begin p = longint'(sa) * longint'(sb_v); return p[63:32]; end
      3'd2: begin p = longint'(sa) * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb_v;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return sa % sb_v;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return 2;
    if (b == 0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Drive one instruction, hold vld until accepted, record the expected commit
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic rd_en);
    exp_t e;
    int w;
    @(negedge clk);
    mext_inst_vld     = 1'b1;
    mext_inst_pld     = $urandom;
    mext_inst_pld[14:12] = f3;
    mext_inst_idx     = tag;
    mext_inst_rd      = rd;
    mext_inst_rd_en   = rd_en;
    mext_inst_pc      = $urandom;
    mext_inst_rs1_val = a;
    mext_inst_rs2_val = b;
    w = 0;
    while (!mext_inst_rdy && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("accept_ready", {63'b0, mext_inst_rdy}, 64'd1);
    if (!mext_inst_rdy) begin
      mext_inst_vld = 1'b0;
      return;
    end
    e.idx   = tag;
    e.wr_en = rd_en && (rd != 0);
    e.rd    = rd;
    e.data  = model(f3, a, b);
    e.acc   = cyc + 1;
    e.lat   = latency(f3, a, b);
    sb.push_back(e);
    tag = tag + 1'b1;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    mext_inst_vld = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: compare each commit against the scoreboard head, police idle outputs and rdy while busy
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (mext_commit_vld) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_commit actual_idx=%0d expected=none at cycle %0d", mext_commit_idx, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("commit_idx", 64'(mext_commit_idx), 64'(e.idx));
          chk("wr_en", 64'(mext_reg_wr_en), 64'(e.wr_en));
          chk("wr_idx", 64'(mext_reg_wr_idx), 64'(e.rd));
          chk("wr_data", 64'(mext_reg_wr_data), 64'(e.data));
          chk("latency", 64'(cyc - e.acc), 64'(e.lat));
          chk("rdy_at_commit", 64'(mext_inst_rdy), 64'd1);
        end
      end else begin
        chk("wr_en_idle", 64'(mext_reg_wr_en), 64'd0);
        if (sb.size() > 0 && sb[0].acc <= cyc) begin
          chk("rdy_busy", 64'(mext_inst_rdy), 64'd0);
          if (cyc - sb[0].acc > sb[0].lat + 4) begin
            checks++; errors++;
            $display("FAIL commit_timeout actual=none expected_idx=%0d at cycle %0d", sb[0].idx, cyc);
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    mext_inst_vld = 1'b0; mext_inst_pld = '0; mext_inst_idx = '0; mext_inst_rd = '0;
    mext_inst_rd_en = 1'b0; mext_inst_pc = '0; mext_inst_rs1_val = '0; mext_inst_rs2_val = '0;
    repeat (3) @(negedge clk);
    chk("reset_rdy", 64'(mext_inst_rdy), 64'd1);
    chk("reset_commit", 64'(mext_commit_vld), 64'd0);
    chk("reset_wr_en", 64'(mext_reg_wr_en), 64'd0);
    chk("reset_wr_data", 64'(mext_reg_wr_data), 64'd0);
    rst_n = 1'b1;

    // Directed cases, issued back-to-back with vld held high
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1);
    issue(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 1'b1);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 1'b1);
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1'b1);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 1'b1);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 1'b1);
    issue(3'd5, 32'd100, 32'd7, 5'd11, 1'b1);
    issue(3'd7, 32'd100, 32'd7, 5'd12, 1'b1);
    issue(3'd5, 32'd5, 32'd0, 5'd13, 1'b1);
    issue(3'd6, 32'd5, 32'd0, 5'd14, 1'b1);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1'b1);
    issue(3'd0, 32'd3, 32'd4, 5'd0, 1'b1);
    issue(3'd7, 32'hFFFF_FFFF, 32'h8000_0000, 5'd20, 1'b0);
    idle(3);

    // Randomized mix with occasional gaps
    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 3));
    end
    idle(40);

    // Reset in the middle of a divide drops it without a commit
    issue(3'd4, 32'd1000, 32'd7, 5'd3, 1'b1);
    @(negedge clk);
    mext_inst_vld = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_rdy", 64'(mext_inst_rdy), 64'd1);
    chk("midreset_commit", 64'(mext_commit_vld), 64'd0);
    chk("midreset_wr_en", 64'(mext_reg_wr_en), 64'd0);
    chk("midreset_wr_data", 64'(mext_reg_wr_data), 64'd0);
    chk("midreset_commit_idx", 64'(mext_commit_idx), 64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1);
    idle(2);

    for (int w = 0; w < 100 && sb.size() > 0; w++) @(negedge clk);
    chk("drain", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
